// File: rtl/uart_pkg.sv
// Shared UART transmit types: FSM state encoding, line levels and a frame-size helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    function automatic int frame_bits(input int data_w, input int stop_bits, input int p);
        return 1 + data_w + p + stop_bits;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head entry is always presented on rd_data.
// Latency: a write is visible at the head on the cycle after it is accepted.
// Backpressure: writes while full and reads while empty are ignored.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_wr;
    logic             do_rd;

    // Same index with opposite wrap bits means the write side has lapped the read side.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter, LSB first; UART_TX_PARITY_EN adds a parity bit and parity_odd.
// Latency: write accepted at edge N drives the start bit from edge N+2; queued frames run back to back.
// Backpressure: s_ready is FIFO not-full; writes presented while full are dropped.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DIV_W-1:0]               baud_div,
`ifdef UART_TX_PARITY_EN
    input  logic                           parity_odd,
`endif
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [DATA_W-1:0]              s_data,
    output logic                           txd,
    output logic                           busy,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);

    localparam logic [3:0] LAST_DATA = 4'(DATA_W - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    tx_state_t          state;
    logic [DATA_W-1:0]  shift_q;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   baud_cnt;
    logic [3:0]         bit_cnt;
    logic [DATA_W-1:0]  head;
    logic [DIV_W-1:0]   div_eff;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               bit_end;
    logic               line_bit;
`ifdef UART_TX_PARITY_EN
    logic               par_q;
`endif

    uart_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (s_valid),
        .wr_data (s_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign s_ready = ~fifo_full;
    assign busy    = (state != IDLE) || (fifo_level != '0);
    assign div_eff = (baud_div == '0) ? DIV_W'(1) : baud_div;
    assign bit_end = (baud_cnt == '0);

    // Popping at the end of the last stop bit lets the next start bit follow with no idle gap.
    always_comb begin
        pop      = 1'b0;
        line_bit = LINE_IDLE;
        case (state)
            IDLE:    pop = ~fifo_empty;
            START:   line_bit = LINE_START;
            DATA:    line_bit = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  line_bit = par_q;
`endif
            STOP:    pop = bit_end && (bit_cnt == LAST_STOP) && ~fifo_empty;
            default: line_bit = LINE_IDLE;
        endcase
    end

    // txd is registered from the current state, so the line trails the FSM by one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            txd      <= LINE_IDLE;
            shift_q  <= '0;
            div_q    <= DIV_W'(1);
            baud_cnt <= '0;
            bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            txd <= line_bit;
            if (pop) begin
                state    <= START;
                shift_q  <= head;
                div_q    <= div_eff;
                baud_cnt <= div_eff - DIV_W'(1);
                bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
                par_q    <= parity_odd ? ~^head : ^head;
`endif
            end else if (state != IDLE) begin
                if (!bit_end) begin
                    baud_cnt <= baud_cnt - DIV_W'(1);
                end else begin
                    baud_cnt <= div_q - DIV_W'(1);
                    case (state)
                        START: state <= DATA;
                        DATA: begin
                            shift_q <= shift_q >> 1;
                            if (bit_cnt == LAST_DATA) begin
                                bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                                state   <= PARITY;
`else
                                state   <= STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
`ifdef UART_TX_PARITY_EN
                        PARITY: state <= STOP;
`endif
                        STOP: begin
                            if (bit_cnt == LAST_STOP) begin
                                state <= IDLE;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule
